// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ write-back units.
// Define WBARB_STALL_CNT_EN to add per-requester saturating stall counters (stall_cnt).
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*RAW-1:0]  req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_RegWrite,
  output logic [RAW-1:0]       rf_rd,
  output logic [XLEN-1:0]      rf_WriteData,
  output logic [(2**RAW)-1:0]  wb_pending_mask,
  output logic [GW-1:0]        grant_id
`ifdef WBARB_STALL_CNT_EN
  ,
  output logic [NREQ*16-1:0]   stall_cnt
`endif
);

  logic [GW-1:0]       r_rrPtr;
  logic                r_regWrite;
  logic [RAW-1:0]      r_rd;
  logic [XLEN-1:0]     r_data;
  logic [GW-1:0]       r_grantId;

  logic [NREQ-1:0]     w_ready;
  logic                w_fire;
  logic [GW-1:0]       w_gntIdx;
  logic [GW-1:0]       w_idx;
  logic [RAW-1:0]      w_selRd;
  logic [XLEN-1:0]     w_selData;
  logic [(2**RAW)-1:0] w_mask;

  // Scan upward from the round-robin pointer; first valid requester wins.
  always_comb begin
    w_ready  = '0;
    w_fire   = 1'b0;
    w_gntIdx = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(r_rrPtr) + k >= NREQ) w_idx = GW'(int'(r_rrPtr) + k - NREQ);
      else                           w_idx = GW'(int'(r_rrPtr) + k);
      if (!w_fire && req_valid[w_idx]) begin
        w_fire          = 1'b1;
        w_ready[w_idx]  = 1'b1;
        w_gntIdx        = w_idx;
      end
    end
    if (rst || wb_hold) begin
      w_ready = '0;
      w_fire  = 1'b0;
    end
  end

  assign w_selRd   = req_rd[int'(w_gntIdx)*RAW +: RAW];
  assign w_selData = req_data[int'(w_gntIdx)*XLEN +: XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr    <= '0;
      r_regWrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_grantId  <= '0;
    end else if (w_fire) begin
      r_rrPtr    <= (int'(w_gntIdx) == NREQ-1) ? '0 : w_gntIdx + 1'b1;
      r_rd       <= w_selRd;
      r_data     <= w_selData;
      r_grantId  <= w_gntIdx;
      // x0 writes are accepted but never reach the port
      r_regWrite <= (w_selRd != '0);
    end else begin
      r_regWrite <= 1'b0;
    end
  end

  always_comb begin
    w_mask = '0;
    if (r_regWrite) w_mask[r_rd] = 1'b1;
  end

  assign req_ready       = w_ready;
  assign rf_RegWrite     = r_regWrite;
  assign rf_rd           = r_rd;
  assign rf_WriteData    = r_data;
  assign grant_id        = r_grantId;
  assign wb_pending_mask = w_mask;

`ifdef WBARB_STALL_CNT_EN
  logic [15:0] r_stallCnt [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_stall
    always_ff @(posedge clk) begin
      if (rst)
        r_stallCnt[i] <= '0;
      else if (req_valid[i] && !w_ready[i] && r_stallCnt[i] != 16'hFFFF)
        r_stallCnt[i] <= r_stallCnt[i] + 16'd1;
    end
    assign stall_cnt[i*16 +: 16] = r_stallCnt[i];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: spec-level model compared every cycle
// plus directed literal checks. Define WBARB_STALL_CNT_EN to also cover stall_cnt.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wbHold;
  logic [2:0]  reqValid;
  logic [14:0] reqRd;
  logic [95:0] reqData;
  logic [2:0]  reqReady;
  logic        rfRegWrite;
  logic [4:0]  rfRd;
  logic [31:0] rfWriteData;
  logic [31:0] wbPendingMask;
  logic [1:0]  grantId;
`ifdef WBARB_STALL_CNT_EN
  logic [47:0] stallCnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  regfile_wb_arbiter #(.NREQ(3), .XLEN(32), .RAW(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_hold         (wbHold),
    .req_valid       (reqValid),
    .req_rd          (reqRd),
    .req_data        (reqData),
    .req_ready       (reqReady),
    .rf_RegWrite     (rfRegWrite),
    .rf_rd           (rfRd),
    .rf_WriteData    (rfWriteData),
    .wb_pending_mask (wbPendingMask),
    .grant_id        (grantId)
`ifdef WBARB_STALL_CNT_EN
    ,
    .stall_cnt       (stallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the write stage and pointer must hold according to the rules
  int          mPtr;
  bit          mWe;
  int          mRd;
  logic [31:0] mData;
  int          mGid;
  int          mStall [3];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Winner index from the round-robin rule, or -1 when nobody may be granted
  function automatic int expGrant();
    if (rst || wbHold) return -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (mPtr + k) % 3;
      if (reqValid[i]) return i;
    end
    return -1;
  endfunction

  // Model update on each rising edge using the inputs stable before it
  always @(posedge clk) begin
    int g;
    g = expGrant();
    for (int i = 0; i < 3; i++)
      if (rst) mStall[i] = 0;
      else if (reqValid[i] && g != i && mStall[i] < 65535) mStall[i] = mStall[i] + 1;
    if (rst) begin
      mPtr = 0; mWe = 0; mRd = 0; mData = 0; mGid = 0;
      checkEn = 1;
    end else if (g >= 0) begin
      mPtr  = (g + 1) % 3;
      mRd   = int'(reqRd[g*5 +: 5]);
      mData = reqData[g*32 +: 32];
      mGid  = g;
      mWe   = (mRd != 0);
    end else begin
      mWe = 0;
    end
  end

  // Compare every cycle on the falling edge once the model has seen a reset
  always @(negedge clk) begin
    if (checkEn) begin
      int g;
      logic [2:0] expRdy;
      g = expGrant();
      expRdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      checkOutput("m_req_ready", 64'(reqReady), 64'(expRdy));
      checkOutput("m_rf_RegWrite", 64'(rfRegWrite), 64'(mWe));
      checkOutput("m_rf_rd", 64'(rfRd), 64'(mRd));
      checkOutput("m_rf_WriteData", 64'(rfWriteData), 64'(mData));
      checkOutput("m_grant_id", 64'(grantId), 64'(mGid));
      checkOutput("m_pending_mask", 64'(wbPendingMask), mWe ? (64'd1 << mRd) : 64'd0);
`ifdef WBARB_STALL_CNT_EN
      for (int i = 0; i < 3; i++)
        checkOutput("m_stall_cnt", 64'(stallCnt[i*16 +: 16]), 64'(mStall[i]));
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic h, input logic [2:0] v);
    @(posedge clk);
    #2;
    rst      = r;
    wbHold   = h;
    reqValid = v;
  endtask

  initial begin
    rst = 1'b1; wbHold = 1'b0; reqValid = 3'b000;
    reqRd   = {5'd0, 5'd0, 5'd5};
    reqData = {32'h0, 32'h0, 32'hDEADBEEF};

    // Single request right after a one-cycle reset
    applyStimulus(1, 0, 3'b000);
    applyStimulus(0, 0, 3'b001);
    @(negedge clk);
    checkOutput("reset_regwrite", 64'(rfRegWrite), 64'd0);
    checkOutput("reset_rd", 64'(rfRd), 64'd0);
    checkOutput("reset_data", 64'(rfWriteData), 64'd0);
    checkOutput("single_ready", 64'(reqReady), 64'b001);
    applyStimulus(0, 0, 3'b000);
    @(negedge clk);
    checkOutput("single_regwrite", 64'(rfRegWrite), 64'd1);
    checkOutput("single_rd", 64'(rfRd), 64'd5);
    checkOutput("single_data", 64'(rfWriteData), 64'hDEADBEEF);
    checkOutput("single_mask", 64'(wbPendingMask), 64'h20);
    checkOutput("single_gid", 64'(grantId), 64'd0);
    applyStimulus(0, 0, 3'b000);
    @(negedge clk);
    checkOutput("single_pulse_end", 64'(rfRegWrite), 64'd0);

    // Round-robin with all three valid from pointer 0
    reqRd   = {5'd3, 5'd2, 5'd1};
    reqData = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    applyStimulus(1, 0, 3'b000);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 3'b111);
      @(negedge clk);
      checkOutput("rr_ready", 64'(reqReady), 64'(1 << (k % 3)));
      if (k > 0) begin
        checkOutput("rr_regwrite", 64'(rfRegWrite), 64'd1);
        checkOutput("rr_gid", 64'(grantId), 64'((k - 1) % 3));
      end
    end

    // x0 write from requester 1: accepted, dropped, pointer moves to 2
    reqRd   = {5'd7, 5'd0, 5'd4};
    reqData = {32'h7777_7777, 32'h1234_5678, 32'h4444_4444};
    applyStimulus(0, 0, 3'b010);
    @(negedge clk);
    checkOutput("x0_ready", 64'(reqReady), 64'b010);
    applyStimulus(0, 0, 3'b111);
    @(negedge clk);
    checkOutput("x0_regwrite", 64'(rfRegWrite), 64'd0);
    checkOutput("x0_mask", 64'(wbPendingMask), 64'd0);
    checkOutput("x0_gid", 64'(grantId), 64'd1);
    checkOutput("x0_ptr_to_2", 64'(reqReady), 64'b100);

    // Grant 0 (pointer becomes 1), then hold for 4 cycles
    applyStimulus(0, 0, 3'b001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 3'b111);
      @(negedge clk);
      checkOutput("hold_ready", 64'(reqReady), 64'd0);
      checkOutput("hold_regwrite", 64'(rfRegWrite), (k == 0) ? 64'd1 : 64'd0);
    end
    applyStimulus(0, 0, 3'b111);
    @(negedge clk);
    checkOutput("hold_resume", 64'(reqReady), 64'b010);

    // Reset right after a grant cancels the pending write
    applyStimulus(1, 0, 3'b111);
    @(negedge clk);
    checkOutput("rst_ready", 64'(reqReady), 64'd0);
    applyStimulus(0, 0, 3'b110);
    @(negedge clk);
    checkOutput("rst_cancel", 64'(rfRegWrite), 64'd0);
    checkOutput("rst_rd", 64'(rfRd), 64'd0);
    checkOutput("rst_data", 64'(rfWriteData), 64'd0);
    checkOutput("rst_lowest", 64'(reqReady), 64'b010);

    // Mixed traffic and holds checked by the model only
    for (int k = 0; k < 24; k++) begin
      reqRd   = {5'(k + 3), 5'(k % 4), 5'(31 - k)};
      reqData = {32'(k * 3), 32'(k * 7 + 1), 32'hF000_0000 + 32'(k)};
      applyStimulus(0, (k % 7) == 3, 3'((k * 5) % 8));
    end

`ifdef WBARB_STALL_CNT_EN
    // Requester 2 contends with 0 and 1 for 9 cycles: ready on 3 of them
    applyStimulus(1, 0, 3'b000);
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 3'b111);
    applyStimulus(0, 0, 3'b000);
    @(negedge clk);
    checkOutput("stall_cnt2_9cyc", 64'(stallCnt[47:32]), 64'd6);
    for (int k = 0; k < 70000; k++) applyStimulus(0, 1, 3'b100);
    applyStimulus(0, 0, 3'b000);
    @(negedge clk);
    checkOutput("stall_cnt2_sat", 64'(stallCnt[47:32]), 64'hFFFF);
`endif

    applyStimulus(0, 0, 3'b000);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
